// File: rtl/seg7_pkg.sv
// seg7_pkg: scan states, hex glyph table and blank pattern for the 7-segment scan driver
package seg7_pkg;
  typedef enum logic [1:0] {SHOW_D0, GAP0, SHOW_D1, GAP1} state_e;
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: 4-bit nibble to active-high 7-segment glyph (bit0=a .. bit6=g)
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  assign o_seg = GLYPH[i_nibble];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: two-digit multiplexed 7-seg driver with blanking gaps; option SEG7_LEADING_ZERO_BLANK_EN
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SHOW_CYCLES    = 50000,
  parameter int GAP_CYCLES     = 500,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_value,
  input  logic       i_load,
  input  logic       i_blank,
  output logic [6:0] o_digitalTube,
  output logic       o_sel,
  output logic       o_frame
);
  localparam int MAX_CYCLES = SHOW_CYCLES > GAP_CYCLES ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = GAP_CYCLES > 0;
  localparam logic [6:0] SEG_FLIP = SEG_ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] disp_q, disp_d, pend_q, pend_d;
  logic [6:0] seg_q, seg_d, glyph;
  logic [3:0] nibble;
  logic sel_q, sel_d, frame_q, frame_d, last, show;
  hex_to_seg7 u_hex (
    .i_nibble(nibble),
    .o_seg   (glyph)
  );
  always_comb begin
    show = state_q == SHOW_D0 || state_q == SHOW_D1;
    last = cnt_q == (show ? SHOW_LAST : GAP_LAST);
    cnt_d = last ? '0 : cnt_q + CW'(1);
    state_d = !last ? state_q
      : state_q == SHOW_D0 ? (HAS_GAP ? GAP0 : SHOW_D1)
      : state_q == GAP0 ? SHOW_D1
      : state_q == SHOW_D1 ? (HAS_GAP ? GAP1 : SHOW_D0)
      : SHOW_D0;
    frame_d = state_d == SHOW_D0 && state_q != SHOW_D0;
    pend_d = i_load ? i_value : pend_q;
    disp_d = frame_d ? pend_d : disp_q;
    nibble = state_d == SHOW_D1 ? disp_d[7:4] : disp_d[3:0];
    sel_d = state_d == SHOW_D0 ? 1'b0 : state_d == SHOW_D1 ? 1'b1 : sel_q;
  end
  always_comb begin
    seg_d = ((i_blank || state_d == GAP0 || state_d == GAP1 ||
              (LZB && state_d == SHOW_D1 && disp_d[7:4] == 4'h0)) ? SEG_BLANK : glyph) ^ SEG_FLIP;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= SHOW_D0;
      cnt_q <= '0;
      disp_q <= '0;
      pend_q <= '0;
      seg_q <= GLYPH[0] ^ SEG_FLIP;
      sel_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      seg_q <= seg_d;
      sel_q <= sel_d;
      frame_q <= frame_d;
    end
  end
  assign o_digitalTube = seg_q;
  assign o_sel = sel_q;
  assign o_frame = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: random loads/blanks/resets on two configurations checked against a frame-position model
module tb_seg7_scan_driver;
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, load, blank;
  logic [7:0] value;
  logic [6:0] seg_a, seg_b;
  logic sel_a, sel_b, frame_a, frame_b;
  int n_chk = 0;
  int n_pass = 0;
  int t = 0;
  bit started = 1'b0;
  logic [7:0] pend = '0;
  logic [7:0] disp [2] = '{8'h00, 8'h00};
  logic [8:0] want_a, want_b;
  always #5 clk = ~clk;
  seg7_scan_driver #(.SHOW_CYCLES(4), .GAP_CYCLES(1), .SEG_ACTIVE_LOW(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_value(value), .i_load(load), .i_blank(blank),
    .o_digitalTube(seg_a), .o_sel(sel_a), .o_frame(frame_a)
  );
  seg7_scan_driver #(.SHOW_CYCLES(4), .GAP_CYCLES(0), .SEG_ACTIVE_LOW(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_value(value), .i_load(load), .i_blank(blank),
    .o_digitalTube(seg_b), .o_sel(sel_b), .o_frame(frame_b)
  );
  function automatic logic [8:0] model_out(int s, int g, bit al, int tt, logic [7:0] d, bit blk);
    int p;
    logic [6:0] seg;
    logic sel;
    p = tt % (2 * (s + g));
    sel = p >= s + g;
    if (blk || (p >= s && p < s + g) || p >= 2 * s + g) seg = 7'h00;
    else if (!sel) seg = GLYPH[d[3:0]];
    else seg = (LZB && d[7:4] == 4'h0) ? 7'h00 : GLYPH[d[7:4]];
    if (al) seg = ~seg;
    return {sel, p == 0 && tt > 0, seg};
  endfunction
  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0d got sel/frame/seg=%h want %h", tag, t, got, want);
  endtask
  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      pend = '0;
      disp[0] = '0;
      disp[1] = '0;
    end else begin
      t++;
      if (t % 10 == 0) disp[0] = load ? value : pend;
      if (t % 8 == 0) disp[1] = load ? value : pend;
      if (load) pend = value;
    end
    want_a = model_out(4, 1, 1'b0, t, disp[0], blank && !rst);
    want_b = model_out(4, 0, 1'b1, t, disp[1], blank && !rst);
    started = 1'b1;
  end
  always @(negedge clk) begin
    if (started) begin
      chk("cfg_a", {sel_a, frame_a, seg_a}, want_a);
      chk("cfg_b", {sel_b, frame_b, seg_b}, want_b);
    end
  end
  initial begin
    int blank_left;
    blank_left = 0;
    rst = 1'b1;
    load = 1'b0;
    blank = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst = (c % 700) >= 350 && (c % 700) < 353;
      load = $urandom_range(0, 5) == 0;
      value = 8'($urandom);
      if (blank_left == 0 && $urandom_range(0, 60) == 0) blank_left = $urandom_range(1, 8);
      blank = blank_left > 0;
      if (blank_left > 0) blank_left--;
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a two-digit common-cathode 7-segment display.
- Takes an 8-bit value, decodes each nibble to a hex glyph and alternates digits at a programmable refresh rate.
- Inserts a blanking gap between digits to suppress ghosting.
- Produces o_digitalTube/o_sel, which feed the debug LED display controller and the board segment pins.

Parameters:
- SHOW_CYCLES, 50000: clock cycles each digit is lit; legal range ≥1.
- GAP_CYCLES, 500: blank cycles after each digit; 0 means gap states are skipped.
- SEG_ACTIVE_LOW, 0: 1 inverts all seven segment outputs, including the blank pattern.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_value  in  8  value to display; [3:0] is digit 0 (right), [7:4] is digit 1 (left).
- i_load  in  1  single-cycle strobe that captures i_value.
- i_blank  in  1  forces segments off while high; scanning continues.
- o_digitalTube  out  7  segment drive; bit0=a … bit6=g; active-high unless SEG_ACTIVE_LOW.
- o_sel  out  1  digit select; 0 = digit 0, 1 = digit 1.
- o_frame  out  1  one-cycle pulse when a new frame starts.

Behaviour:
- Reset is synchronous and active-high on i_clk. Reset state:
  - state=SHOW_D0, dwell counter=0, display reg=0x00, pending reg=0x00.
  - o_sel=0, o_digitalTube=glyph '0' (0x3F), o_frame=0.
- FSM states: SHOW_D0 → GAP0 → SHOW_D1 → GAP1 → SHOW_D0.
  - When GAP_CYCLES=0, transitions are SHOW_D0 → SHOW_D1 → SHOW_D0.
- Dwell counter:
  - Counts 0..N-1 in each state (N=SHOW_CYCLES or GAP_CYCLES), then clears on transition.
  - Width is $clog2(max(SHOW_CYCLES,GAP_CYCLES)+1).
- Frame period is 2*(SHOW_CYCLES+GAP_CYCLES) cycles.
- Loading:
  - i_load writes i_value into the pending reg on any cycle; last write wins.
  - The display reg updates only on the edge entering SHOW_D0 (frame boundary), so digits never tear.
  - If i_load is high on that same edge, i_value goes straight into the display reg (bypass).
- o_frame is high for exactly the first cycle of each SHOW_D0 after the first post-reset one. It is not asserted out of reset.
- Outputs are registered and change on the same edge as the state register. There is no combinational input→output path.
  - SHOW_D0: o_sel=0, segs=glyph(display[3:0]).
  - SHOW_D1: o_sel=1, segs=glyph(display[7:4]).
  - GAPx: o_sel holds the previous digit's value; segs=blank (0x00, or 0x7F when SEG_ACTIVE_LOW).
  - i_blank is sampled each cycle and forces blank segs one cycle later. Scan state is unaffected.
- Glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (pre-inversion).
- Reset mid-frame: pending and display regs are discarded; the next edge restores the full reset state.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: when display[7:4]==0, digit 1 shows blank during SHOW_D1; o_sel and timing are unchanged.
- Undefined: a high nibble of 0 shows glyph '0'.

Decomposition:
- Package seg7_pkg contains:
  - the state enum (SHOW_D0, GAP0, SHOW_D1, GAP1);
  - the 16-entry glyph constant table;
  - SEG_BLANK=7'h00.
- One combinational sub-module, hex_to_seg7 (4-bit nibble → 7-bit glyph), instantiated once and muxed by state.

Test Plan:
- Reset with SHOW=4, GAP=1: o_sel=0, segs=0x3F, o_frame=0. Hold i_rst for 3 cycles mid-frame → the same values appear the edge after assertion.
- Load 0xA5 at cycle 2 (SHOW=4, GAP=1): the next frame shows 0x6D (o_sel=0) for 4 cycles, 0x00 for 1, 0x77 (o_sel=1) for 4, 0x00 for 1. o_frame pulses at each SHOW_D0 entry.
- Load 0x12 mid-SHOW_D1, then 0x34 one cycle later: the current frame is unchanged; the next frame shows 4/3 glyphs (0x66/0x4F). 0x12 is never displayed.
- i_load=1 with i_value=0xF0 on the exact GAP1→SHOW_D0 edge: the first SHOW_D0 cycle shows 0x3F, then SHOW_D1 shows 0x71 (bypass path).
- GAP_CYCLES=0, SEG_ACTIVE_LOW=1, value 0x08: o_sel alternates every 4 cycles with no blank. Segs are 0x00 ('8' inverted) then 0x40 ('0' inverted). With the macro defined, digit 1 shows 0x7F.
- i_blank high for 6 cycles: segs are blank from the cycle after assertion until the cycle after release; o_sel scan period is unchanged.
